sym9_pattern_gen: RTL

- Inverse of the 9-input symmetric (Z9sym) detector: given a requested Hamming weight k, streams every 9-bit input vector whose popcount equals k.
- Vectors are emitted in ascending numeric order over a valid/ready interface.
- Drives exhaustive stimulus into the symmetric-function PLA blocks and provides their expected output alongside each vector.

---
 rtl/sym9_pattern_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sym9_pattern_gen.sv
// sym9_pattern_gen: streams every 9-bit vector whose popcount equals a
// requested weight k, in ascending numeric order, over a valid/ready port.
// Each vector carries the expected Z9sym output (1 iff 3 <= k <= 6) so the
// stream can drive a symmetric-function block and its checker together.
module sym9_pattern_gen #(
   parameter int N     = 9,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       weight,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_vec,
   output logic             out_last,
   output logic             out_sym,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t     state;
   logic [3:0] k_q;
   // One extra bit so the counter can step past the all-ones pattern
   // without aliasing back to zero.
   logic [N:0] cand;

   logic       cand_hit;
   logic       cand_last;
   logic       sym_k;

   // Popcount of a candidate; 4 bits is enough for the 9-bit vector.
   function automatic logic [3:0] popcount(input logic [N-1:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < N; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

   // Largest vector of weight k: the k ones packed into the top bits.
   function automatic logic [N-1:0] lastpat(input logic [3:0] k);
      logic [N-1:0] p;
      p = '0;
      for (int i = 0; i < N; i++) begin
         if (i >= N - int'(k)) begin
            p[i] = 1'b1;
         end
      end
      return p;
   endfunction

   // Match and termination decode for the candidate examined this cycle.
   assign cand_hit  = (popcount(cand[N-1:0]) == k_q);
   assign cand_last = (cand[N-1:0] == lastpat(k_q));
   assign sym_k     = (k_q >= 4'd3) && (k_q <= 4'd6);

   // Control FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         k_q       <= '0;
         cand      <= '0;
         out_valid <= 1'b0;
         out_vec   <= '0;
         out_last  <= 1'b0;
         out_sym   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         count     <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees
         // the pre-edge register values; the default below turns done into
         // a single-cycle pulse unless a branch re-asserts it.
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  count <= '0;
                  if (weight > 4'd9) begin
                     // Impossible weight: report and finish with no vectors.
                     err  <= 1'b1;
                     done <= 1'b1;
                  end else begin
                     k_q   <= weight;
                     err   <= 1'b0;
                     cand  <= '0;
                     busy  <= 1'b1;
                     state <= SCAN;
                  end
               end
            end

            SCAN: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cand <= cand + (N+1)'(1);
                  if (cand_hit) begin
                     out_vec   <= cand[N-1:0];
                     out_valid <= 1'b1;
                     out_last  <= cand_last;
                     out_sym   <= sym_k;
                     state     <= HOLD;
                  end
               end
            end

            HOLD: begin
               // Abort wins over a same-cycle accept; that vector is dropped.
               if (abort) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (out_ready) begin
                  count     <= count + CNT_W'(1);
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (out_last) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     state <= SCAN;
                  end
               end
            end

            default: begin
               busy      <= 1'b0;
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
